// File: rtl/d_bridge_pkg.sv
// d_bridge_pkg: shared types and helpers for the data-side sram bridge.
//   state_t      : bridge FSM states (IDLE, ADDR, DATA, DONE)
//   SIZE_B/H/W   : sram-like bus size codes (byte, half, word)
//   wen_to_size  : maps a byte write-select pattern to a bus size
package d_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Single lanes are bytes, aligned lane pairs are halves; everything else
  // (including three-lane unaligned-store patterns) goes out as a word.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    logic [1:0] size_v;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_v = SIZE_B;
      4'b0011, 4'b1100:                   size_v = SIZE_H;
      default:                            size_v = SIZE_W;
    endcase
    return size_v;
  endfunction

endpackage

// File: rtl/d_size_enc.sv
// d_size_enc: combinational request-field encoder for the data bridge.
// Ports:
//   mem_wen    in  4       byte write-select (0 = read)
//   mem_rsize  in  2       read size
//   mem_addr   in  ADDR_W  access address
//   data_wr    out 1       1 = write
//   data_size  out 2       bus size
//   data_addr  out ADDR_W  bus address (word-aligned for word accesses)
//   data_wstrb out 4       byte strobe (0 for reads)
module d_size_enc
  import d_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [3:0]        mem_wen,
  input  logic [1:0]        mem_rsize,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb
);

  // Derive direction, size, aligned address and strobe from the M-stage fields.
  always_comb begin
    data_wr    = |mem_wen;
    data_wstrb = mem_wen;
    if (data_wr) begin
      data_size = wen_to_size(mem_wen);
    end else begin
      data_size = mem_rsize;
    end
    if (data_size == SIZE_W) begin
      data_addr = {mem_addr[ADDR_W-1:2], 2'b00};
    end else begin
      data_addr = mem_addr;
    end
  end

endmodule

// File: rtl/d_sram_bridge.sv
// d_sram_bridge: M-stage data access to sram-like bus bridge.
// Issues one bus transaction per M-stage access, stalls the pipeline until it
// completes and holds the returned word until the pipeline advances.
// Optional LL/SC support is enabled with the macro LLBIT_EN.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_en/wen/rsize/addr/wdata  M-stage access
//   flush, longest_stall     pipeline cancel / external hold
//   ll_en, sc_en, llbit_clr  LL/SC controls (used only with LLBIT_EN)
//   mem_rdata, d_stall       raw read word and stall request to the pipeline
//   llbit, sc_ok             LL bit and SC success
//   data_*                   sram-like bus master interface
module d_sram_bridge
  import d_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [1:0]        mem_rsize,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  input  logic              longest_stall,
  input  logic              ll_en,
  input  logic              sc_en,
  input  logic              llbit_clr,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              d_stall,
  output logic              llbit,
  output logic              sc_ok,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_t              state_r;
  state_t              state_n_s;
  logic                cancel_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                wr_r;
  logic [1:0]          size_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [3:0]          wstrb_r;

  logic                enc_wr_s;
  logic [1:0]          enc_size_s;
  logic [ADDR_W-1:0]   enc_addr_s;
  logic [3:0]          enc_wstrb_s;

  logic                req_s;
  logic                stall_s;
  logic                load_s;
  logic                sc_block_s;
  logic                data_done_s;

  d_size_enc #(.ADDR_W(ADDR_W)) u_size_enc (
    .mem_wen    (mem_wen),
    .mem_rsize  (mem_rsize),
    .mem_addr   (mem_addr),
    .data_wr    (enc_wr_s),
    .data_size  (enc_size_s),
    .data_addr  (enc_addr_s),
    .data_wstrb (enc_wstrb_s)
  );

  assign data_done_s = (state_r == DATA) && data_data_ok;

`ifdef LLBIT_EN
  logic ll_r;
  logic llbit_r;

  assign sc_block_s = sc_en & ~llbit_r;
  assign sc_ok      = ~sc_block_s;
  assign llbit      = llbit_r;

  // LL bit: set by a completed, non-cancelled LL read; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      llbit_r <= 1'b0;
    end else if (llbit_clr) begin
      llbit_r <= 1'b0;
    end else if (data_done_s && ll_r && !cancel_r) begin
      llbit_r <= 1'b1;
    end else begin
      llbit_r <= llbit_r;
    end
  end

  // Remember whether the outstanding transaction is an LL read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ll_r <= 1'b0;
    end else if (load_s) begin
      ll_r <= ll_en & ~enc_wr_s;
    end else begin
      ll_r <= ll_r;
    end
  end
`else
  logic unused_s;
  assign unused_s   = ^{ll_en, sc_en, llbit_clr};
  assign sc_block_s = 1'b0;
  assign sc_ok      = 1'b1;
  assign llbit      = 1'b0;
`endif

  // Next state, request issue and stall generation.
  always_comb begin
    state_n_s = state_r;
    req_s     = 1'b0;
    stall_s   = 1'b0;
    load_s    = 1'b0;
    case (state_r)
      IDLE: begin
        req_s   = mem_en & ~flush & ~sc_block_s;
        stall_s = req_s;
        if (req_s) begin
          load_s    = 1'b1;
          state_n_s = data_addr_ok ? DATA : ADDR;
        end else begin
          state_n_s = IDLE;
        end
      end
      ADDR: begin
        // Once offered, the request stays up until accepted.
        req_s   = 1'b1;
        stall_s = 1'b1;
        if (data_addr_ok) begin
          state_n_s = DATA;
        end else begin
          state_n_s = ADDR;
        end
      end
      DATA: begin
        stall_s = ~data_data_ok;
        if (data_data_ok) begin
          state_n_s = (longest_stall && !cancel_r) ? DONE : IDLE;
        end else begin
          state_n_s = DATA;
        end
      end
      DONE: begin
        if (!longest_stall || flush) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = DONE;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
    // An orphaned transaction blocks any new access until it drains.
    if (cancel_r) begin
      stall_s = mem_en;
    end else begin
      stall_s = stall_s;
    end
  end

  // Bus fields come live from the encoder in IDLE, otherwise from the latch.
  always_comb begin
    if (state_r == IDLE) begin
      data_wr    = enc_wr_s;
      data_size  = enc_size_s;
      data_addr  = enc_addr_s;
      data_wdata = mem_wdata;
      data_wstrb = enc_wstrb_s;
    end else begin
      data_wr    = wr_r;
      data_size  = size_r;
      data_addr  = addr_r;
      data_wdata = wdata_r;
      data_wstrb = wstrb_r;
    end
  end

  // Reset forces the handshake outputs low without waiting for a clock edge.
  assign data_req  = req_s & ~rst;
  assign d_stall   = stall_s & ~rst;
  assign mem_rdata = data_done_s ? data_rdata : rdata_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Latch the request fields when a new transaction is launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_r    <= 1'b0;
      size_r  <= 2'd0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      wstrb_r <= 4'd0;
    end else if (load_s) begin
      wr_r    <= enc_wr_s;
      size_r  <= enc_size_s;
      addr_r  <= enc_addr_s;
      wdata_r <= mem_wdata;
      wstrb_r <= enc_wstrb_s;
    end else begin
      wr_r    <= wr_r;
      size_r  <= size_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wstrb_r <= wstrb_r;
    end
  end

  // Cancel marks an in-flight transaction flushed in M; it ends with data_ok.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cancel_r <= 1'b0;
    end else if (data_done_s) begin
      cancel_r <= 1'b0;
    end else if (flush && (state_r == ADDR || state_r == DATA)) begin
      cancel_r <= 1'b1;
    end else begin
      cancel_r <= cancel_r;
    end
  end

  // Hold the returned word; data from a cancelled transaction is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (data_done_s && !cancel_r) begin
      rdata_r <= data_rdata;
    end else begin
      rdata_r <= rdata_r;
    end
  end

endmodule
